audio_sample_fifo: RTL
======================

Name: audio_sample_fifo

Overview:
- Stereo sample buffer and clock-domain crossing. It sits directly upstream of the I2S DAC serializer.
- Accepts left/right sample pairs from the synth engine in the system clock domain through a valid/ready handshake.
- Delivers one pair per LRCK frame in the audio bit-clock domain on stable parallel outputs. The serializer consumes these outputs.
- Primes to a fill threshold before playback starts, and mutes and re-primes on underrun.

Parameters:
- AUD_BIT_DEPTH, 24, width of each channel sample.
- ADDR_W, 4, log2 of FIFO depth in stereo pairs (default depth 16).
- PRIME_LEVEL, 8, pairs that must be buffered before RUN is entered; legal range 1..2**ADDR_W.

Ports:
- sys_clk  in  1  system clock, write side.
- reset_reg_N  in  1  asynchronous, active-low reset for both domains. Deassertion is synchronised separately into each domain.
- iAUDB_CLK  in  1  audio bit clock, read side. All read logic runs on negedge iAUDB_CLK.
- iAUD_DACLRCK  in  1  DAC LR clock, sampled in the iAUDB_CLK domain.
- i_valid  in  1  write request (sys_clk).
- o_ready  out  1  FIFO not full (sys_clk).
- i_lsample  in  AUD_BIT_DEPTH  left sample to write.
- i_rsample  in  AUD_BIT_DEPTH  right sample to write.
- o_level  out  ADDR_W+1  fill level seen from the write side (sys_clk).
- o_lsound_out  out  AUD_BIT_DEPTH  left sample to the serializer (bclk domain).
- o_rsound_out  out  AUD_BIT_DEPTH  right sample to the serializer (bclk domain).
- o_running  out  1  read FSM is in RUN (bclk domain).
- o_underrun  out  1  sticky underrun flag (bclk domain).
- i_clr_underrun  in  1  synchronous clear of o_underrun (bclk domain).

Behaviour:
- Reset (async assert, both domains):
  - Pointers = 0, o_ready = 0, o_level = 0.
  - o_lsound_out = 0, o_rsound_out = 0, o_running = 0, o_underrun = 0.
  - Read FSM = PRIME.
  - o_ready goes to 1 on the second sys_clk edge after reset deassert, via a 2-flop synchroniser.
- Storage: dual-clock RAM of 2**ADDR_W entries, each 2*AUD_BIT_DEPTH wide, {left,right}.
- Pointers: ADDR_W+1 bits binary, converted to Gray for crossing. Each crossing uses a 2-flop synchroniser in the destination domain.
- Write side (posedge sys_clk):
  - A write occurs when i_valid && o_ready. The pair is stored and wptr increments.
  - o_ready = !full, where full = (wptr_gray == {~rsync[MSB:MSB-1], rsync[rest]}).
  - o_level = wptr - rptr_synced. It is pessimistic (over-reports) by up to 3 cycles of read activity.
  - Writes with o_ready = 0 are ignored. No overflow flag; the producer must honour ready.
  - Pointer wrap-around is handled by the extra MSB. Full and empty are distinguished at all depths.
- Read side (negedge iAUDB_CLK):
  - lrck_dly registers iAUD_DACLRCK.
  - frame_tick = lrck_dly & ~iAUD_DACLRCK, i.e. an LRCK falling edge, one pulse per frame.
  - rd_level = wptr_synced - rptr.
- FSM PRIME:
  - Outputs held at 0 and o_running = 0.
  - On frame_tick with rd_level >= PRIME_LEVEL: pop one pair, load o_lsound_out/o_rsound_out from the RAM, go to RUN.
  - The outputs change only on a frame_tick cycle.
- FSM RUN (o_running = 1):
  - On frame_tick with rd_level != 0: pop, and update both outputs in the same cycle.
  - On frame_tick with rd_level == 0: set o_underrun = 1, force both outputs to 0, go to PRIME. rptr is not advanced.
- Output stability:
  - Outputs are constant for a full LRCK period between frame_ticks.
  - The serializer may sample them at any point in the frame.
  - Left and right always come from the same FIFO entry; they never update in different cycles.
- Underrun flag:
  - i_clr_underrun clears o_underrun on the next edge.
  - If an underrun and a clear occur in the same cycle, set wins.
- Latency:
  - Write to visibility on the read side is at most 3 bclk negedges plus 1 sys_clk.
  - Pop to o_ready rising is at most 3 sys_clk edges.
- Reset mid-operation: all state returns to reset values immediately. Any buffered pairs are discarded.
- No combinational paths between domains.

Test Plan:
- Ready after reset: release reset with no writes for 20 frames -> outputs stay 0, o_running = 0, o_ready = 1 by the 2nd sys_clk.
- Priming: write 8 pairs (L=0x000001..0x000008, R=0x100001..0x100008) -> on the first frame_tick after sync, RUN is entered with outputs 0x000001/0x100001. Each later frame_tick steps the outputs to the next pair in order.
- Fill to full: write 16 pairs with LRCK stopped -> o_ready = 0 and o_level = 16. A 17th i_valid is dropped. Restarting LRCK then yields exactly pairs 1..16.
- Underrun: in RUN, stop writes and let the FIFO drain -> on the next frame_tick o_underrun = 1, outputs = 0, o_running = 0. Playback resumes only after 8 new pairs are written. i_clr_underrun clears the flag.
- Set/clear collision: i_clr_underrun asserted on the same edge as an underrun -> o_underrun = 1.
- Async clocks: sys_clk 50 MHz, BCLK 3.072 MHz with jitter, continuous writes paced by ready over 20000 frames -> pairs are received in order, left/right never mixed, no spurious underrun. Assert reset mid-stream -> all outputs 0 within the reset assertion.

Source files
------------

// File: rtl/audio_sample_fifo_if.sv
// Write-side bus of the stereo sample FIFO: producer handshake, sample pair and fill level.
interface audio_sample_fifo_if #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int ADDR_W        = 4
);
    logic                            i_valid;
    logic                            o_ready;
    logic signed [AUD_BIT_DEPTH-1:0] i_lsample;
    logic signed [AUD_BIT_DEPTH-1:0] i_rsample;
    logic [ADDR_W:0]                 o_level;

    modport master (output i_valid, i_lsample, i_rsample, input o_ready, o_level);
    modport slave  (input i_valid, i_lsample, i_rsample, output o_ready, o_level);
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO crossing from sys_clk to the I2S bit clock; primes before playback,
// presents one {left,right} pair per LRCK frame and mutes/re-primes on underrun.
module audio_sample_fifo #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int ADDR_W        = 4,
    parameter int PRIME_LEVEL   = 8
) (
    input  logic                            sys_clk,
    input  logic                            reset_reg_N,
    input  logic                            iAUDB_CLK,
    input  logic                            iAUD_DACLRCK,
    audio_sample_fifo_if.slave              wr_bus,
    output logic signed [AUD_BIT_DEPTH-1:0] o_lsound_out,
    output logic signed [AUD_BIT_DEPTH-1:0] o_rsound_out,
    output logic                            o_running,
    output logic                            o_underrun,
    input  logic                            i_clr_underrun
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] PRIME_LVL = PW'(PRIME_LEVEL);

    typedef enum logic {PRIME, RUN} rd_state_t;

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [2*AUD_BIT_DEPTH-1:0] mem [DEPTH];

    logic            wrst_p0, wrst_p1;
    logic [ADDR_W:0] wptr, wptr_gray, wptr_nxt;
    logic [ADDR_W:0] rgray_p0, rgray_p1;
    logic            full, wr_en;

    logic            rrst_p0, rrst_p1;
    logic [ADDR_W:0] rptr, rptr_gray, rptr_nxt;
    logic [ADDR_W:0] wgray_p0, wgray_p1;
    logic [ADDR_W:0] rd_level;
    logic            lrck_dly, frame_tick;
    logic [2*AUD_BIT_DEPTH-1:0] rd_data;
    rd_state_t       rd_state, rd_state_nxt;
    logic            pop, mute, set_underrun;

    // Write domain: reset release sync, read-pointer sync, pointer and RAM write
    assign full           = (wptr_gray == {~rgray_p1[ADDR_W:ADDR_W-1], rgray_p1[ADDR_W-2:0]});
    assign wr_bus.o_ready = wrst_p1 & ~full;
    assign wr_en          = wr_bus.i_valid & wr_bus.o_ready;
    assign wptr_nxt       = wptr + 1'b1;
    assign wr_bus.o_level = wptr - gray2bin(rgray_p1);

    always_ff @(posedge sys_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wrst_p0   <= 1'b0;
            wrst_p1   <= 1'b0;
            rgray_p0  <= '0;
            rgray_p1  <= '0;
            wptr      <= '0;
            wptr_gray <= '0;
        end else begin
            wrst_p0  <= 1'b1;
            wrst_p1  <= wrst_p0;
            rgray_p0 <= rptr_gray;
            rgray_p1 <= rgray_p0;
            if (wr_en) begin
                wptr      <= wptr_nxt;
                wptr_gray <= bin2gray(wptr_nxt);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wptr[ADDR_W-1:0]] <= {wr_bus.i_lsample, wr_bus.i_rsample};
    end

    // Read domain: everything on the falling bit-clock edge
    assign frame_tick = lrck_dly & ~iAUD_DACLRCK;
    assign rd_level   = gray2bin(wgray_p1) - rptr;
    assign rptr_nxt   = rptr + 1'b1;
    assign rd_data    = mem[rptr[ADDR_W-1:0]];
    assign o_running  = (rd_state == RUN);

    always_comb begin
        rd_state_nxt = rd_state;
        pop          = 1'b0;
        mute         = 1'b0;
        set_underrun = 1'b0;
        if (rrst_p1 && frame_tick) begin
            case (rd_state)
                PRIME: if (rd_level >= PRIME_LVL) begin
                    pop          = 1'b1;
                    rd_state_nxt = RUN;
                end
                RUN: if (rd_level != '0) begin
                    pop = 1'b1;
                end else begin
                    mute         = 1'b1;
                    set_underrun = 1'b1;
                    rd_state_nxt = PRIME;
                end
                default: rd_state_nxt = PRIME;
            endcase
        end
    end

    always_ff @(negedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rrst_p0      <= 1'b0;
            rrst_p1      <= 1'b0;
            lrck_dly     <= 1'b0;
            wgray_p0     <= '0;
            wgray_p1     <= '0;
            rptr         <= '0;
            rptr_gray    <= '0;
            rd_state     <= PRIME;
            o_lsound_out <= '0;
            o_rsound_out <= '0;
            o_underrun   <= 1'b0;
        end else begin
            rrst_p0  <= 1'b1;
            rrst_p1  <= rrst_p0;
            lrck_dly <= iAUD_DACLRCK;
            wgray_p0 <= wptr_gray;
            wgray_p1 <= wgray_p0;
            rd_state <= rd_state_nxt;
            // Both channels load from one RAM word in one cycle so L/R can never split
            if (pop) begin
                o_lsound_out <= rd_data[2*AUD_BIT_DEPTH-1:AUD_BIT_DEPTH];
                o_rsound_out <= rd_data[AUD_BIT_DEPTH-1:0];
                rptr         <= rptr_nxt;
                rptr_gray    <= bin2gray(rptr_nxt);
            end else if (mute) begin
                o_lsound_out <= '0;
                o_rsound_out <= '0;
            end
            if (set_underrun)        o_underrun <= 1'b1;
            else if (i_clr_underrun) o_underrun <= 1'b0;
        end
    end
endmodule
